uart_sci: RTL and testbench
===========================

Name: uart_sci

Overview:
- Bus-mapped 8N1 serial communication interface: 8 data bits, LSB first, one start bit, one stop bit, no parity.
- Exposes four byte registers on a shared bidirectional 8-bit data bus: transmit data, receive data, status and control.
- Provides a programmable baud generator, a transmitter, an 8x-oversampling receiver and one combined interrupt line.
- Sits on the system bus as a peripheral selected by `scisel`.

Parameters:
- BAUD_DIV, 13: system clocks per 8x-oversample tick at baud select 0.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rstb  in  1  reset, asynchronous, active-high.
- scisel  in  1  peripheral select.
- rw  in  1  1 = bus write into the block, 0 = bus read from the block.
- addr  in  2  register address.
- dbus  inout  8  data bus.
- rxd  in  1  serial receive line; idles high.
- txd  out  1  serial transmit line; idles high.
- sciirq  out  1  interrupt request, active-high.

Behaviour:
- Register map:
  - Write 00: TDR. Write 1x (10 or 11): SCCR. Write 01: ignored.
  - Read 00: RDR. Read 01: SCSR. Read 1x: SCCR.
- Bus write: when scisel=1 and rw=1, the addressed register is loaded on each clk edge.
- Bus read: dbus is driven combinationally only when scisel=1 and rw=0. Otherwise dbus is high-Z.
- SCCR bits:
  - [7] TIE, transmit interrupt enable.
  - [6] RIE, receive interrupt enable.
  - [5] LBK, loopback; used only with the optional feature.
  - [4:3] reserved, read back as written.
  - [2:0] SEL, baud select.
- SCSR bits:
  - [7] TDRE, transmit data register empty.
  - [6] RDRF, receive data register full.
  - [5:2] read 0.
  - [1] OE, overrun error.
  - [0] FE, framing error.
- Reset values: TDR=0, RDR=0, SCCR=0, TDRE=1, RDRF=0, OE=0, FE=0, txd=1, sciirq=0, all counters 0, both state machines IDLE.
- Baud generation, as single-clk enables only (no derived clocks):
  - A prescaler counts 0..BAUD_DIV-1 and emits `base` on wrap.
  - An 8-bit counter increments on `base`.
  - `tick8` fires when `base` occurs and the low SEL bits of that counter are all 1s, giving a divide by 2^SEL.
  - `tick1` fires on every 8th `tick8`.
  - Bit period = BAUD_DIV × 8 × 2^SEL clocks, i.e. 104 clocks at SEL=0.
- Transmitter FSM: IDLE → SYNCH → TDATA.
  - IDLE: when TDRE=0, load the 9-bit TSR = {TDR, 0}, set TDRE=1, go to SYNCH.
  - SYNCH: wait for `tick1`, then go to TDATA.
  - TDATA: on each `tick1`, txd = TSR[0], shift right filling with 1. After 10 bit times (start, 8 data, stop = 1), return to IDLE.
- TDR write: clears TDRE. A write while TDRE=0 overwrites TDR; the earlier byte is lost, with no flag.
- Receiver FSM: IDLE → START_DET → RECV, all steps on `tick8` only.
  - IDLE: rxd=0 on a tick → START_DET.
  - START_DET: after 4 ticks, if rxd is still 0 go to RECV; otherwise go back to IDLE (glitch rejection).
  - RECV: sample every 8 ticks. The first 8 samples shift into RSR LSB-first. The 9th sample is the stop bit.
  - At the stop sample: RDR<=RSR, OE<=RDRF (old value), FE<=~stop bit, RDRF<=1. Then return to IDLE.
- Reading RDR (scisel=1, rw=0, addr=00) clears RDRF, OE and FE on that clk edge. Reading SCSR has no side effect.
- Simultaneous RDR read and stop sample: the reception wins; RDRF=1 with the new data.
- sciirq = (RIE & (RDRF | OE)) | (TIE & TDRE), registered.
- SEL change mid-frame takes effect at the next tick. No frame protection is provided.
- Reset mid-frame aborts both FSMs immediately and txd returns to 1.

Optional Feature:
- UART_LOOPBACK_EN defined: when SCCR[5]=1, the receiver input is the internal txd and the rxd pin is ignored.
- UART_LOOPBACK_EN undefined: SCCR[5] is a plain storage bit and the receiver always uses rxd.

Decomposition:
- Package `uart_sci_pkg` holds:
  - register address constants;
  - SCCR/SCSR bit-index constants;
  - tx and rx state enums;
  - frame length constants (10 bits, 8x oversample, mid-point 4).
- One natural sub-module: `uart_sci_baudgen`, covering the prescaler, the select logic and the `tick8`/`tick1` outputs.
- The FSMs and the register file stay in the top.

Test Plan:
- Reset → txd=1, sciirq=0. SCSR read = 0x80 and SCCR read = 0x00, both once dbus is driven.
- Write SCCR=0x40, write TDR=0x6B, rxd tied to txd:
  - txd shows 0, then 1,1,0,1,0,1,1,0, then 1, each level 104 clocks.
  - Afterwards RDR=0x6B, SCSR=0xC0, sciirq=1.
- After the loopback frame, read RDR → 0x6B on dbus, RDRF clears, sciirq falls.
- Receive two bytes, 0x55 then 0xA3, without reading → RDR=0xA3, OE=1, SCSR=0xC2.
- Drive a frame with the stop bit 0 → FE=1. A 2-clock low glitch on idle rxd does not start reception.
- SEL=3 → 832-clock bit period. TIE=1 with TDRE=1 → sciirq=1; a write to TDR drops TDRE until the load, then sciirq returns to 1.

Source files
------------

// File: rtl/uart_sci_pkg.sv
// rtl/uart_sci_pkg.sv - shared constants, bit indices and FSM state types for the uart_sci block
package uart_sci_pkg;

  localparam logic [1:0] ADDR_TDR  = 2'b00;
  localparam logic [1:0] ADDR_RDR  = 2'b00;
  localparam logic [1:0] ADDR_SCSR = 2'b01;

  localparam int SCCR_TIE  = 7;
  localparam int SCCR_RIE  = 6;
  localparam int SCCR_LBK  = 5;
  localparam int SCSR_TDRE = 7;
  localparam int SCSR_RDRF = 6;
  localparam int SCSR_OE   = 1;
  localparam int SCSR_FE   = 0;

  localparam int FRAME_BITS = 10;
  localparam int OVERSAMPLE = 8;
  localparam int MID_TICKS  = 4;
  localparam int DATA_BITS  = 8;

  typedef enum logic [1:0] {TX_IDLE, TX_SYNCH, TX_TDATA} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START_DET, RX_RECV} rx_state_t;

endpackage

// File: rtl/uart_sci_baudgen.sv
// rtl/uart_sci_baudgen.sv - prescaler and baud select producing single-clock tick8/tick1 enables
module uart_sci_baudgen #(
  parameter int BAUD_DIV = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sel,
  output logic       tick8,
  output logic       tick1
);

  localparam int PW = $clog2(BAUD_DIV + 1);

  logic [PW-1:0] pre;
  logic [7:0]    bcnt;
  logic [2:0]    t8cnt;
  logic          base;
  logic [7:0]    mask;

  assign base  = (pre == PW'(BAUD_DIV - 1));
  // the low SEL bits of bcnt all set gives one base in 2^SEL
  assign mask  = 8'((9'd1 << sel) - 9'd1);
  assign tick8 = base && ((bcnt & mask) == mask);
  assign tick1 = tick8 && (t8cnt == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre   <= '0;
      bcnt  <= '0;
      t8cnt <= '0;
    end else begin
      pre <= base ? '0 : pre + PW'(1);
      if (base)  bcnt  <= bcnt + 8'd1;
      if (tick8) t8cnt <= t8cnt + 3'd1;
    end
  end

endmodule

// File: rtl/uart_sci.sv
// rtl/uart_sci.sv - bus-mapped 8N1 UART with TDR/RDR/SCSR/SCCR registers and one interrupt line
// Optional receiver loopback via SCCR[5] when UART_LOOPBACK_EN is defined.
module uart_sci
  import uart_sci_pkg::*;
#(
  parameter int BAUD_DIV = 13
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       scisel,
  input  logic       rw,
  input  logic [1:0] addr,
  inout  wire  [7:0] dbus,
  input  logic       rxd,
  output logic       txd,
  output logic       sciirq
);

  tx_state_t   tx_state;
  rx_state_t   rx_state;
  logic [7:0]  tdr, rdr, sccr, rsr, rdata;
  logic [8:0]  tsr;
  logic [3:0]  tx_bits, rx_bits;
  logic [2:0]  rx_cnt;
  logic        tdre, rdrf, oe, fe;
  logic [1:0]  rxd_sync;
  logic        rx_in, tick8, tick1;
  logic        wr_tdr, wr_sccr, rd_rdr;

  assign wr_tdr  = scisel && rw && (addr == ADDR_TDR);
  assign wr_sccr = scisel && rw && addr[1];
  assign rd_rdr  = scisel && !rw && (addr == ADDR_RDR);

  always_comb begin
    rdata = sccr;
    if (addr == ADDR_RDR)       rdata = rdr;
    else if (addr == ADDR_SCSR) rdata = {tdre, rdrf, 4'b0000, oe, fe};
  end

  assign dbus = (scisel && !rw) ? rdata : 8'bz;

`ifdef UART_LOOPBACK_EN
  assign rx_in = sccr[SCCR_LBK] ? txd : rxd_sync[1];
`else
  assign rx_in = rxd_sync[1];
`endif

  uart_sci_baudgen #(.BAUD_DIV(BAUD_DIV)) u_baudgen (
    .clk   (clk),
    .rst   (rstb),
    .sel   (sccr[2:0]),
    .tick8 (tick8),
    .tick1 (tick1)
  );

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      sccr     <= '0;
      sciirq   <= 1'b0;
      rxd_sync <= 2'b11;
    end else begin
      if (wr_sccr) sccr <= dbus;
      rxd_sync <= {rxd_sync[0], rxd};
      sciirq   <= (sccr[SCCR_RIE] && (rdrf || oe)) || (sccr[SCCR_TIE] && tdre);
    end
  end

  // Transmitter; a TDR write placed after the FSM wins over a same-cycle load.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      tx_state <= TX_IDLE;
      tsr      <= '1;
      tx_bits  <= '0;
      tdr      <= '0;
      tdre     <= 1'b1;
      txd      <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: if (!tdre) begin
          tsr      <= {tdr, 1'b0};
          tdre     <= 1'b1;
          tx_bits  <= '0;
          tx_state <= TX_SYNCH;
        end
        TX_SYNCH: if (tick1) tx_state <= TX_TDATA;
        TX_TDATA: if (tick1) begin
          if (tx_bits == 4'(FRAME_BITS)) begin
            tx_state <= TX_IDLE;
          end else begin
            txd     <= tsr[0];
            tsr     <= {1'b1, tsr[8:1]};
            tx_bits <= tx_bits + 4'd1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
      if (wr_tdr) begin
        tdr  <= dbus;
        tdre <= 1'b0;
      end
    end
  end

  // Receiver; the stop-sample update follows the read clear so a new byte wins.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rsr      <= '0;
      rdr      <= '0;
      rdrf     <= 1'b0;
      oe       <= 1'b0;
      fe       <= 1'b0;
    end else begin
      if (rd_rdr) begin
        rdrf <= 1'b0;
        oe   <= 1'b0;
        fe   <= 1'b0;
      end
      if (tick8) begin
        case (rx_state)
          RX_IDLE: if (!rx_in) begin
            rx_cnt   <= '0;
            rx_state <= RX_START_DET;
          end
          RX_START_DET: begin
            if (rx_cnt == 3'(MID_TICKS - 1)) begin
              rx_cnt   <= '0;
              rx_bits  <= '0;
              rx_state <= rx_in ? RX_IDLE : RX_RECV;
            end else begin
              rx_cnt <= rx_cnt + 3'd1;
            end
          end
          RX_RECV: begin
            if (rx_cnt == 3'(OVERSAMPLE - 1)) begin
              rx_cnt <= '0;
              if (rx_bits == 4'(DATA_BITS)) begin
                rdr      <= rsr;
                oe       <= rdrf;
                fe       <= !rx_in;
                rdrf     <= 1'b1;
                rx_state <= RX_IDLE;
              end else begin
                rsr     <= {rx_in, rsr[7:1]};
                rx_bits <= rx_bits + 4'd1;
              end
            end else begin
              rx_cnt <= rx_cnt + 3'd1;
            end
          end
          default: rx_state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_sci.sv
// tb/tb_uart_sci.sv - directed self-checking bench for uart_sci
module tb_uart_sci;

  logic       clk = 1'b0;
  logic       rstb;
  logic       scisel;
  logic       rw;
  logic [1:0] addr;
  logic [7:0] dout;
  logic       den;
  logic       rxd_drv;
  logic       loop;
  wire  [7:0] dbus;
  wire        rxd;
  wire        txd;
  wire        sciirq;
  int         errors = 0;
  int         checks = 0;

  assign dbus = den ? dout : 8'bz;
  assign rxd  = loop ? txd : rxd_drv;

  always #5 clk = ~clk;

  uart_sci #(.BAUD_DIV(13)) dut (
    .clk    (clk),
    .rstb   (rstb),
    .scisel (scisel),
    .rw     (rw),
    .addr   (addr),
    .dbus   (dbus),
    .rxd    (rxd),
    .txd    (txd),
    .sciirq (sciirq)
  );

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    scisel = 1'b1; rw = 1'b1; addr = a; dout = d; den = 1'b1;
    @(negedge clk);
    scisel = 1'b0; rw = 1'b0; den = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    scisel = 1'b1; rw = 1'b0; addr = a; den = 1'b0;
    #1 d = dbus;
    @(negedge clk);
    scisel = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rxd_drv = 1'b0;
    repeat (104) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      repeat (104) @(negedge clk);
    end
    rxd_drv = stop_bit;
    repeat (104) @(negedge clk);
    rxd_drv = 1'b1;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    rstb = 1'b1; scisel = 1'b0; rw = 1'b0; addr = 2'b00; dout = 8'h00; den = 1'b0;
    rxd_drv = 1'b1; loop = 1'b0;
    repeat (3) @(negedge clk);
    rstb = 1'b0;
    @(negedge clk);
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got=%b exp=1", txd); end
    checks++; if (sciirq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", sciirq); end
    bus_read(2'b01, d);
    checks++; if (d !== 8'h80) begin errors++; $display("FAIL reset_scsr got=%h exp=80", d); end
    bus_read(2'b10, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_sccr got=%h exp=00", d); end
    bus_write(2'b11, 8'h5A);
    bus_read(2'b10, d);
    checks++; if (d !== 8'h5A) begin errors++; $display("FAIL sccr_rw got=%h exp=5a", d); end
    bus_write(2'b01, 8'hFF);
    bus_read(2'b11, d);
    checks++; if (d !== 8'h5A) begin errors++; $display("FAIL wr01_ignored got=%h exp=5a", d); end
    bus_read(2'b01, d);
    checks++; if (d !== 8'h80) begin errors++; $display("FAIL scsr_after_wr01 got=%h exp=80", d); end
    bus_write(2'b10, 8'h00);
  endtask

  task automatic test_loopback;
    logic [7:0] d;
    logic [7:0] exp_byte;
    int cnt;
    exp_byte = 8'h6B;
    loop = 1'b1;
    bus_write(2'b10, 8'h40);
    bus_write(2'b00, 8'h6B);
    cnt = 0;
    while (txd === 1'b1 && cnt < 400) begin @(negedge clk); cnt++; end
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL lb_start_seen got=%b exp=0", txd); end
    cnt = 0;
    while (txd === 1'b0 && cnt < 200) begin @(negedge clk); cnt++; end
    checks++; if (cnt != 104) begin errors++; $display("FAIL lb_start_len got=%0d exp=104", cnt); end
    repeat (52) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (txd !== exp_byte[i]) begin errors++; $display("FAIL lb_bit%0d got=%b exp=%b", i, txd, exp_byte[i]); end
      repeat (104) @(negedge clk);
    end
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL lb_stop got=%b exp=1", txd); end
    repeat (104) @(negedge clk);
    bus_read(2'b01, d);
    checks++; if (d !== 8'hC0) begin errors++; $display("FAIL lb_scsr got=%h exp=c0", d); end
    checks++; if (sciirq !== 1'b1) begin errors++; $display("FAIL lb_irq got=%b exp=1", sciirq); end
    loop = 1'b0;
  endtask

  task automatic test_read_clear;
    logic [7:0] d;
    bus_read(2'b00, d);
    checks++; if (d !== 8'h6B) begin errors++; $display("FAIL rdr_read got=%h exp=6b", d); end
    repeat (2) @(negedge clk);
    checks++; if (sciirq !== 1'b0) begin errors++; $display("FAIL rd_irq_fall got=%b exp=0", sciirq); end
    bus_read(2'b01, d);
    checks++; if (d !== 8'h80) begin errors++; $display("FAIL rd_scsr got=%h exp=80", d); end
  endtask

  task automatic test_overrun;
    logic [7:0] d;
    send_frame(8'h55, 1'b1);
    send_frame(8'hA3, 1'b1);
    repeat (60) @(negedge clk);
    bus_read(2'b01, d);
    checks++; if (d !== 8'hC2) begin errors++; $display("FAIL ovr_scsr got=%h exp=c2", d); end
    bus_read(2'b00, d);
    checks++; if (d !== 8'hA3) begin errors++; $display("FAIL ovr_rdr got=%h exp=a3", d); end
    bus_read(2'b01, d);
    checks++; if (d !== 8'h80) begin errors++; $display("FAIL ovr_clear got=%h exp=80", d); end
  endtask

  task automatic test_framing;
    logic [7:0] d;
    send_frame(8'h3C, 1'b0);
    repeat (200) @(negedge clk);
    bus_read(2'b01, d);
    checks++; if (d !== 8'hC1) begin errors++; $display("FAIL fe_scsr got=%h exp=c1", d); end
    bus_read(2'b00, d);
    checks++; if (d !== 8'h3C) begin errors++; $display("FAIL fe_rdr got=%h exp=3c", d); end
    bus_read(2'b01, d);
    checks++; if (d !== 8'h80) begin errors++; $display("FAIL fe_clear got=%h exp=80", d); end
  endtask

  task automatic test_glitch;
    logic [7:0] d;
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (2) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (1200) @(negedge clk);
    bus_read(2'b01, d);
    checks++; if (d !== 8'h80) begin errors++; $display("FAIL glitch_scsr got=%h exp=80", d); end
  endtask

  task automatic test_sel3;
    int cnt;
    bus_write(2'b10, 8'h03);
    bus_write(2'b00, 8'h01);
    cnt = 0;
    while (txd === 1'b1 && cnt < 3000) begin @(negedge clk); cnt++; end
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL sel3_start_seen got=%b exp=0", txd); end
    cnt = 0;
    while (txd === 1'b0 && cnt < 2000) begin @(negedge clk); cnt++; end
    checks++; if (cnt != 832) begin errors++; $display("FAIL sel3_bit_len got=%0d exp=832", cnt); end
    repeat (7800) @(negedge clk);
  endtask

  task automatic test_tie_back_to_back;
    logic [7:0] d;
    int cnt;
    bus_write(2'b10, 8'h80);
    repeat (2) @(negedge clk);
    checks++; if (sciirq !== 1'b1) begin errors++; $display("FAIL tie_irq got=%b exp=1", sciirq); end
    bus_write(2'b00, 8'hAA);
    bus_write(2'b00, 8'h55);
    repeat (3) @(negedge clk);
    checks++; if (sciirq !== 1'b0) begin errors++; $display("FAIL tie_busy_irq got=%b exp=0", sciirq); end
    bus_read(2'b01, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL tie_busy_scsr got=%h exp=00", d); end
    cnt = 0;
    while (sciirq !== 1'b1 && cnt < 2500) begin @(negedge clk); cnt++; end
    checks++; if (sciirq !== 1'b1) begin errors++; $display("FAIL tie_irq_return got=%b exp=1", sciirq); end
    bus_read(2'b01, d);
    checks++; if (d !== 8'h80) begin errors++; $display("FAIL tie_scsr_return got=%h exp=80", d); end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] d;
    int cnt;
    cnt = 0;
    while (txd === 1'b1 && cnt < 600) begin @(negedge clk); cnt++; end
    repeat (20) @(negedge clk);
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL mid_txd_low got=%b exp=0", txd); end
    rstb = 1'b1;
    #1;
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL mid_rst_txd got=%b exp=1", txd); end
    @(negedge clk);
    rstb = 1'b0;
    bus_read(2'b01, d);
    checks++; if (d !== 8'h80) begin errors++; $display("FAIL mid_rst_scsr got=%h exp=80", d); end
    bus_read(2'b10, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL mid_rst_sccr got=%h exp=00", d); end
    cnt = 0;
    repeat (300) begin @(negedge clk); if (txd !== 1'b1) cnt++; end
    checks++; if (cnt != 0) begin errors++; $display("FAIL mid_rst_idle low_cycles=%0d exp=0", cnt); end
  endtask

  initial begin
    test_reset;
    test_loopback;
    test_read_clear;
    test_overrun;
    test_framing;
    test_glitch;
    test_sel3;
    test_tie_back_to_back;
    test_reset_midframe;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
